// File: rtl/mixcolumns_seq.sv
// rtl/mixcolumns_seq.sv - iterative AES MixColumns engine, COLS columns per pass
// Optional inverse transform enabled by defining MIXCOL_INV_EN.
module mixcolumns_seq #(
    parameter int COLS = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);
    localparam int N  = 4 / COLS;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] count;
    logic [127:0]  work;
    logic [127:0]  work_nxt;
    logic          inv_eff;
    logic          accept;
    logic          last_pass;
    int            idx;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Inverse = forward MixColumns after folding 4*(a0^a2) / 4*(a1^a3) into the column.
    function automatic logic [31:0] mixcol(input logic [31:0] c, input logic inv);
        logic [7:0] a0, a1, a2, a3, u, v;
        {a0, a1, a2, a3} = c;
        u = xt(xt(a0 ^ a2));
        v = xt(xt(a1 ^ a3));
        if (inv) begin
            a0 = a0 ^ u;
            a2 = a2 ^ u;
            a1 = a1 ^ v;
            a3 = a3 ^ v;
        end
        return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    endfunction

    assign in_ready  = reset_n & ((state == IDLE) | ((state == DONE) & out_ready));
    assign accept    = in_valid & in_ready;
    assign last_pass = (state == BUSY) && (count == LAST);
    assign out_valid = (state == DONE);
    assign busy      = (state == BUSY);

`ifdef MIXCOL_INV_EN
    logic inv_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inv_q <= 1'b0;
        end else if (!clear && accept) begin
            inv_q <= in_inv;
        end
    end

    assign inv_eff = inv_q;
`else
    logic unused_inv;

    assign unused_inv = in_inv;
    assign inv_eff    = 1'b0;
`endif

    // Only the COLS columns selected by count pass through the mix logic this cycle.
    always_comb begin
        work_nxt = work;
        idx      = 0;
        for (int i = 0; i < COLS; i++) begin
            idx = int'(count) * COLS + i;
            work_nxt[127 - 32*idx -: 32] = mixcol(work[127 - 32*idx -: 32], inv_eff);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = BUSY;
            BUSY:    if (last_pass) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = in_valid ? BUSY : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            count    <= '0;
            work     <= '0;
            out_data <= '0;
        end else if (clear) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                work  <= in_data;
                count <= '0;
            end else if (state == BUSY) begin
                work  <= work_nxt;
                count <= last_pass ? '0 : count + CW'(1);
                if (last_pass) begin
                    out_data <= work_nxt;
                end
            end
        end
    end
endmodule
